// File: rtl/instr_mem_pipe.sv
// Synchronous instruction memory for IF: 1- or 2-stage registered read with stall/flush,
// carried fetch address and misalign/out-of-range flags. Define INSTR_MEM_WRITE_EN for a byte-strobed write port.
module instr_mem_pipe #(
  parameter int                ADDR_W    = 11,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 512,
  parameter int                LATENCY   = 1,
  parameter string             INIT_FILE = "program.hex",
  parameter logic [DATA_W-1:0] NOP_WORD  = 32'h00000013
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_stall,
  input  logic                i_flush,
`ifdef INSTR_MEM_WRITE_EN
  input  logic                i_we,
  input  logic [ADDR_W-1:0]   i_waddr,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wstrb,
`endif
  output logic [DATA_W-1:0]   o_rdata,
  output logic                o_valid,
  output logic [ADDR_W-1:0]   o_addr,
  output logic                o_misalign,
  output logic                o_oob
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              mis;
    logic              oob;
  } stage_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-3:0] idx;
  logic              mis, oob, acc;
  stage_t            in_st;
  stage_t            st [1:LATENCY];
  logic [LATENCY:1]  vld_pipe;

  // Words not otherwise preloaded must read as 0.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  assign idx = i_addr[ADDR_W-1:2];
  assign mis = |i_addr[1:0];
  assign oob = 32'(idx) >= 32'(DEPTH);
  assign acc = i_req && !i_stall && !i_flush;

  always_comb begin
    in_st = '{data: NOP_WORD, addr: i_addr, mis: mis, oob: oob};
    if (!mis && !oob) in_st.data = mem[idx[IW-1:0]];
  end

  // Payload only loads behind a valid entry so o_addr keeps the last real response.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      vld_pipe <= '0;
      for (int s = 1; s <= LATENCY; s++)
        st[s] <= '{data: NOP_WORD, addr: '0, mis: 1'b0, oob: 1'b0};
    end else if (i_flush) begin
      vld_pipe <= '0;
    end else if (!i_stall) begin
      vld_pipe[1] <= acc;
      if (acc) st[1] <= in_st;
      for (int s = 2; s <= LATENCY; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) st[s] <= st[s-1];
      end
    end
  end

  assign o_valid    = vld_pipe[LATENCY];
  assign o_rdata    = o_valid ? st[LATENCY].data : NOP_WORD;
  assign o_addr     = st[LATENCY].addr;
  assign o_misalign = o_valid & st[LATENCY].mis;
  assign o_oob      = o_valid & st[LATENCY].oob;

`ifdef INSTR_MEM_WRITE_EN
  logic [ADDR_W-3:0] widx;
  assign widx = i_waddr[ADDR_W-1:2];

  // Nonblocking update gives read-before-write on a same-cycle collision.
  always_ff @(posedge i_clk) begin
    if (i_we && i_waddr[1:0] == 2'b00 && 32'(widx) < 32'(DEPTH))
      for (int k = 0; k < DATA_W/8; k++)
        if (i_wstrb[k]) mem[widx[IW-1:0]][8*k +: 8] <= i_wdata[8*k +: 8];
  end
`endif
endmodule

// File: tb/tb_instr_mem_pipe.sv
// Scoreboard bench: two instances (LATENCY=1/DEPTH=512, LATENCY=2/DEPTH=256) share stimulus.
module tb_instr_mem_pipe;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst, req, stall, flush;
  logic [10:0] addr;
  logic [31:0] rd0, rd1;
  logic [10:0] a0, a1;
  logic        v0, v1, m0, m1, b0, b1;

  int checks = 0, failures = 0;

  typedef struct {
    logic [31:0] data;
    logic [10:0] addr;
    logic        mis;
    logic        oob;
  } exp_t;

  exp_t        q0[$], q1[$];
  logic        ev1[2], ev2[2], pv[2];
  logic [31:0] pd[2];
  logic [10:0] pa[2], last_a[2];

  always #5 clk = ~clk;

  instr_mem_pipe #(.ADDR_W(11), .DATA_W(32), .DEPTH(512), .LATENCY(1), .INIT_FILE(""), .NOP_WORD(NOP)) u1 (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_addr(addr), .i_stall(stall), .i_flush(flush),
    .o_rdata(rd0), .o_valid(v0), .o_addr(a0), .o_misalign(m0), .o_oob(b0));

  instr_mem_pipe #(.ADDR_W(11), .DATA_W(32), .DEPTH(256), .LATENCY(2), .INIT_FILE(""), .NOP_WORD(NOP)) u2 (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_addr(addr), .i_stall(stall), .i_flush(flush),
    .o_rdata(rd1), .o_valid(v1), .o_addr(a1), .o_misalign(m1), .o_oob(b1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int i);
    return (i == 3) ? 32'h00500093 : (32'h0A000000 ^ (i * 32'h00010101));
  endfunction

  function automatic exp_t exp_of(input int k, input logic [10:0] a);
    exp_t e;
    int   wi = int'(a[10:2]);
    e.addr = a;
    e.mis  = (a[1:0] != 2'b00);
    e.oob  = wi >= ((k == 0) ? 512 : 256);
    e.data = (e.mis || e.oob) ? NOP : word_of(wi);
    return e;
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++) begin
      ev1[k] = 1'b0; ev2[k] = 1'b0; pv[k] = 1'b0;
      pd[k] = NOP; pa[k] = '0; last_a[k] = '0;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_v0"}, 32'(v0), 0);           chk({tag, "_v1"}, 32'(v1), 0);
    chk({tag, "_rd0"}, rd0, NOP);            chk({tag, "_rd1"}, rd1, NOP);
    chk({tag, "_a0"}, 32'(a0), 0);           chk({tag, "_a1"}, 32'(a1), 0);
    chk({tag, "_fl0"}, 32'({m0, b0}), 0);    chk({tag, "_fl1"}, 32'({m1, b1}), 0);
  endtask

  // Called 1 time unit after each rising edge; inputs are still those seen at the edge.
  task automatic update(input int k);
    logic        ov, om, ob, acc, expv;
    logic [31:0] od;
    logic [10:0] oa;
    exp_t        e;
    if (k == 0) begin ov = v0; od = rd0; oa = a0; om = m0; ob = b0; end
    else        begin ov = v1; od = rd1; oa = a1; om = m1; ob = b1; end
    acc = req && !stall && !flush;
    if (stall && !flush) begin
      chk($sformatf("u%0d_hold_valid", k), 32'(ov), 32'(pv[k]));
      chk($sformatf("u%0d_hold_data", k), od, pd[k]);
      chk($sformatf("u%0d_hold_addr", k), 32'(oa), 32'(pa[k]));
    end else begin
      if (flush) begin
        ev1[k] = 1'b0; ev2[k] = 1'b0;
        if (k == 0) q0.delete(); else q1.delete();
      end else begin
        ev2[k] = ev1[k];
        ev1[k] = acc;
        if (acc) begin
          if (k == 0) q0.push_back(exp_of(0, addr)); else q1.push_back(exp_of(1, addr));
        end
      end
      expv = (k == 0) ? ev1[k] : ev2[k];
      chk($sformatf("u%0d_valid", k), 32'(ov), 32'(expv));
      if (ov && expv) begin
        if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
        chk($sformatf("u%0d_data@%h", k, e.addr), od, e.data);
        chk($sformatf("u%0d_addr", k), 32'(oa), 32'(e.addr));
        chk($sformatf("u%0d_flags@%h", k, e.addr), 32'({om, ob}), 32'({e.mis, e.oob}));
        last_a[k] = e.addr;
      end else if (!ov) begin
        chk($sformatf("u%0d_idle_data", k), od, NOP);
        chk($sformatf("u%0d_idle_flags", k), 32'({om, ob}), 0);
        chk($sformatf("u%0d_idle_addr", k), 32'(oa), 32'(last_a[k]));
      end
    end
    pv[k] = ov; pd[k] = od; pa[k] = oa;
  endtask

  task automatic step(input logic r, input logic [10:0] a, input logic s, input logic f);
    req = r; addr = a; stall = s; flush = f;
    @(posedge clk);
    #1;
    update(0);
    update(1);
  endtask

  logic [31:0] rr;
  logic [10:0] ra;

  initial begin
    rst = 1'b1; req = 1'b0; addr = '0; stall = 1'b0; flush = 1'b0;
    #1;
    for (int i = 0; i < 512; i++) u1.mem[i] = word_of(i);
    for (int i = 0; i < 256; i++) u2.mem[i] = word_of(i);
    #20;
    chk_reset("por");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Single fetch of word 3
    step(1'b1, 11'h00C, 1'b0, 1'b0);
    chk("t1_valid", 32'(v0), 1);
    chk("t1_rdata", rd0, 32'h00500093);
    chk("t1_addr", 32'(a0), 32'h00C);
    step(1'b0, 11'h000, 1'b0, 1'b0);
    chk("t1_l2_rdata", rd1, 32'h00500093);

    // Back-to-back stream
    step(1'b1, 11'h000, 1'b0, 1'b0);
    step(1'b1, 11'h004, 1'b0, 1'b0);
    step(1'b1, 11'h008, 1'b0, 1'b0);
    step(1'b0, 11'h000, 1'b0, 1'b0);
    step(1'b0, 11'h000, 1'b0, 1'b0);

    // Three stalled cycles with changing address mid-stream
    step(1'b1, 11'h010, 1'b0, 1'b0);
    step(1'b1, 11'h014, 1'b0, 1'b0);
    step(1'b1, 11'h020, 1'b1, 1'b0);
    step(1'b1, 11'h024, 1'b1, 1'b0);
    step(1'b1, 11'h028, 1'b1, 1'b0);
    step(1'b1, 11'h018, 1'b0, 1'b0);
    step(1'b0, 11'h000, 1'b0, 1'b0);
    step(1'b0, 11'h000, 1'b0, 1'b0);

    // Flush beats stall with two fetches in flight
    step(1'b1, 11'h01C, 1'b0, 1'b0);
    step(1'b1, 11'h020, 1'b0, 1'b0);
    step(1'b1, 11'h024, 1'b1, 1'b1);
    chk("flush_valid", 32'(v1), 0);
    chk("flush_rdata", rd1, NOP);
    step(1'b1, 11'h028, 1'b0, 1'b0);
    step(1'b0, 11'h000, 1'b0, 1'b0);
    step(1'b0, 11'h000, 1'b0, 1'b0);

    // Misaligned and out-of-range fetches
    step(1'b1, 11'h006, 1'b0, 1'b0);
    chk("mis_flag", 32'(m0), 1);
    chk("mis_rdata", rd0, NOP);
    step(1'b1, 11'h400, 1'b0, 1'b0);
    step(1'b1, 11'h7FC, 1'b0, 1'b0);
    chk("oob_flag", 32'(b1), 1);
    step(1'b1, 11'h402, 1'b0, 1'b0);
    step(1'b0, 11'h000, 1'b0, 1'b0);
    step(1'b0, 11'h000, 1'b0, 1'b0);

    // Random mix of requests, bubbles, stalls and flushes
    for (int n = 0; n < 80; n++) begin
      rr = $urandom;
      ra = 11'(rr);
      if (rr[12]) ra[1:0] = 2'b00;
      step(rr[15:14] != 2'b00, ra, rr[20:17] < 4'd3, rr[25:22] == 4'd0);
    end
    step(1'b0, 11'h000, 1'b0, 1'b0);
    step(1'b0, 11'h000, 1'b0, 1'b0);

    // Asynchronous reset mid-transfer while stalled
    step(1'b1, 11'h004, 1'b0, 1'b0);
    step(1'b1, 11'h008, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("async_rst");
    @(posedge clk);
    #1;
    chk_reset("rst_held");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    step(1'b1, 11'h00C, 1'b0, 1'b0);
    step(1'b0, 11'h000, 1'b0, 1'b0);
    step(1'b0, 11'h000, 1'b0, 1'b0);
    chk("drain_u1", 32'(q0.size()), 0);
    chk("drain_u2", 32'(q1.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
